// File: rtl/be_block_streamer.sv
// ---------------------------------------------------------------------------
// be_block_streamer
//
// Converts 128-bit big-endian blocks into a stream of 32-bit little-endian
// words. Stream byte 0 of a block is block[127:120]; each output word carries
// four consecutive stream bytes with the earliest byte in word[7:0].
// A 2-entry block buffer decouples the upstream block interface from the
// downstream word interface and allows 1 word/cycle across block boundaries.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   block_valid   upstream block present
//   block_ready   buffer has a free entry (count != 2)
//   block         128-bit BE data block
//   block_last    block ends a message
//   block_nbytes  valid bytes in a last block (1..16, 0 means 16)
//   word_valid    output word present (count != 0)
//   word_ready    downstream accepts word
//   word          32-bit LE output word
//   word_keep     byte enables for word
//   word_last     final word of a message
//   empty         no buffered block and no pending word
// ---------------------------------------------------------------------------
module be_block_streamer (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         block_valid,
    output logic         block_ready,
    input  logic [127:0] block,
    input  logic         block_last,
    input  logic [4:0]   block_nbytes,
    output logic         word_valid,
    input  logic         word_ready,
    output logic [31:0]  word,
    output logic [3:0]   word_keep,
    output logic         word_last,
    output logic         empty
);

    // Block buffer storage; contents are qualified by count, so no reset.
    logic [127:0] buf_data_reg   [2];
    logic         buf_last_reg   [2];
    logic [4:0]   buf_nbytes_reg [2];

    logic       wr_ptr_reg, wr_ptr_next;
    logic       rd_ptr_reg, rd_ptr_next;
    logic [1:0] count_reg,  count_next;
    logic [1:0] idx_reg,    idx_next;

    logic [127:0] rd_data;
    logic         rd_last;
    logic [4:0]   rd_nbytes;
    logic [4:0]   nb_eff;
    logic [1:0]   final_idx;
    logic         at_final;
    logic [31:0]  seg;
    logic         wr_en;
    logic         rd_en;
    logic         retire;

    // Handshake status comes straight from registered occupancy.
    assign block_ready = (count_reg != 2'd2);
    assign word_valid  = (count_reg != 2'd0);
    assign empty       = (count_reg == 2'd0);

    assign rd_data   = buf_data_reg[rd_ptr_reg];
    assign rd_last   = buf_last_reg[rd_ptr_reg];
    assign rd_nbytes = buf_nbytes_reg[rd_ptr_reg];

    assign wr_en  = block_valid & block_ready;
    assign rd_en  = word_valid & word_ready;
    assign retire = rd_en & at_final;

    // Effective byte count of the entry at the read pointer: zero (and any
    // out-of-range value) means a full block.
    always_comb begin
        nb_eff = rd_nbytes;
        if ((rd_nbytes == 5'd0) || (rd_nbytes > 5'd16)) begin
            nb_eff = 5'd16;
        end
    end

    // Index of the last word the entry produces: ceil(nb_eff/4) - 1.
    always_comb begin
        final_idx = 2'd3;
        if (rd_last) begin
            if (nb_eff > 5'd12) begin
                final_idx = 2'd3;
            end else if (nb_eff > 5'd8) begin
                final_idx = 2'd2;
            end else if (nb_eff > 5'd4) begin
                final_idx = 2'd1;
            end else begin
                final_idx = 2'd0;
            end
        end
    end

    assign at_final = (idx_reg == final_idx);

    // Select the 32-bit big-endian segment addressed by idx.
    always_comb begin
        seg = rd_data[127:96];
        case (idx_reg)
            2'd0:    seg = rd_data[127:96];
            2'd1:    seg = rd_data[95:64];
            2'd2:    seg = rd_data[63:32];
            default: seg = rd_data[31:0];
        endcase
    end

    // Byte swap: the earliest stream byte (segment MSB) lands in word[7:0].
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_swap
            assign word[8*gi +: 8] = seg[(31 - 8*gi) -: 8];
        end
    endgenerate

    // word_last is gated by word_valid so reset state reads 0 regardless of
    // the unreset buffer contents. Bytes past nbytes are not masked.
    assign word_last = word_valid & rd_last & at_final;

    always_comb begin
        word_keep = 4'b1111;
        if (word_last) begin
            case (nb_eff[1:0])
                2'd1:    word_keep = 4'b0001;
                2'd2:    word_keep = 4'b0011;
                2'd3:    word_keep = 4'b0111;
                default: word_keep = 4'b1111;
            endcase
        end
    end

    always_comb begin
        wr_ptr_next = wr_en  ? ~wr_ptr_reg : wr_ptr_reg;
        rd_ptr_next = retire ? ~rd_ptr_reg : rd_ptr_reg;

        count_next = count_reg;
        case ({wr_en, retire})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase

        idx_next = idx_reg;
        if (rd_en) begin
            idx_next = at_final ? 2'd0 : (idx_reg + 2'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
            idx_reg    <= 2'd0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            idx_reg    <= idx_next;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_data_reg[wr_ptr_reg]   <= block;
            buf_last_reg[wr_ptr_reg]   <= block_last;
            buf_nbytes_reg[wr_ptr_reg] <= block_nbytes;
        end
    end

endmodule

// File: tb/tb_be_block_streamer.sv
// ---------------------------------------------------------------------------
// tb_be_block_streamer
//
// Scoreboard bench: each accepted block is expanded by a byte-level model into
// expected words pushed on a queue; a negedge monitor pops and compares every
// transferred word, tracks occupancy, and checks hold stability.
// ---------------------------------------------------------------------------
module tb_be_block_streamer;

    typedef struct packed {
        logic [31:0] w;
        logic [3:0]  k;
        logic        l;
        logic        f;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         block_valid;
    logic         block_ready;
    logic [127:0] block;
    logic         block_last;
    logic [4:0]   block_nbytes;
    logic         word_valid;
    logic         word_ready;
    logic [31:0]  word;
    logic [3:0]   word_keep;
    logic         word_last;
    logic         empty;

    be_block_streamer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .block_valid  (block_valid),
        .block_ready  (block_ready),
        .block        (block),
        .block_last   (block_last),
        .block_nbytes (block_nbytes),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .word         (word),
        .word_keep    (word_keep),
        .word_last    (word_last),
        .empty        (empty)
    );

    exp_t sb[$];
    int   pop_cyc[$];
    int   tests    = 0;
    int   errors   = 0;
    int   accepted = 0;
    int   retired  = 0;
    int   pops     = 0;
    int   nblocks  = 0;
    int   cyc      = 0;
    int   last_acc_cyc = 0;
    int   ready_mode   = 1;   // 0: stall, 1: always ready, 2: random

    logic        hold_prev = 1'b0;
    logic [31:0] hold_w;
    logic [3:0]  hold_k;
    logic        hold_l;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: stream byte k of a block is block[127-8k -: 8]; each
    // word holds 4 consecutive stream bytes, earliest byte lowest.
    task automatic push_expected(input logic [127:0] d, input bit l, input logic [4:0] nb);
        int   n;
        int   nw;
        int   k;
        exp_t e;
        n  = (!l || nb == 0) ? 16 : int'(nb);
        nw = (n + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            e = '0;
            for (int j = 0; j < 4; j++) begin
                k = 4 * w + j;
                e.w[8*j +: 8] = d[127 - 8*k -: 8];
                e.k[j] = (k < n);
            end
            e.f = (w == nw - 1);
            e.l = l && e.f;
            sb.push_back(e);
        end
    endtask

    // Downstream readiness, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       word_ready = 1'b0;
            1:       word_ready = 1'b1;
            default: word_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        int   occ;
        exp_t e;
        cyc++;
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            occ = accepted - retired;
            chk("word_valid_vs_occ", {31'd0, word_valid}, {31'd0, occ != 0});
            chk("block_ready_vs_occ", {31'd0, block_ready}, {31'd0, occ != 2});
            chk("empty_vs_occ", {31'd0, empty}, {31'd0, occ == 0});
            if (hold_prev) begin
                chk("hold_valid", {31'd0, word_valid}, 32'd1);
                chk("hold_word", word, hold_w);
                chk("hold_keep", {28'd0, word_keep}, {28'd0, hold_k});
                chk("hold_last", {31'd0, word_last}, {31'd0, hold_l});
            end
            if (word_valid && word_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", word, 32'hxxxxxxxx);
                end else begin
                    e = sb.pop_front();
                    chk("word", word, e.w);
                    chk("word_keep", {28'd0, word_keep}, {28'd0, e.k});
                    chk("word_last", {31'd0, word_last}, {31'd0, e.l});
                    if (e.f) retired++;
                end
                pops++;
                pop_cyc.push_back(cyc);
            end
            hold_prev = word_valid && !word_ready;
            hold_w    = word;
            hold_k    = word_keep;
            hold_l    = word_last;
        end
    end

    // Called at a rising edge; returns at the rising edge where the block is
    // written so consecutive calls keep block_valid high with no gap.
    task automatic send_block(input logic [127:0] d, input bit l, input logic [4:0] nb);
        bit acc;
        bit done;
        done = 1'b0;
        #1;
        block_valid  = 1'b1;
        block        = d;
        block_last   = l;
        block_nbytes = nb;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            acc = block_ready;
            @(posedge clk);
            if (acc) begin
                push_expected(d, l, nb);
                accepted++;
                nblocks++;
                last_acc_cyc = cyc;
                done = 1'b1;
                $display("[TB] block %0d data=%h last=%0d nbytes=%0d", nblocks, d, l, nb);
            end
        end
        if (!done) begin
            chk("block_accept_timeout", 32'd0, 32'd1);
            #1 block_valid = 1'b0;
        end
    endtask

    // Waits for the scoreboard to drain, then checks the buffer reports empty.
    task automatic wait_drain(input string name);
        int i;
        for (i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            chk({name, "_drain_timeout"}, sb.size(), 32'd0);
            sb.delete();
        end
        @(negedge clk);
        chk({name, "_empty"}, {31'd0, empty}, 32'd1);
    endtask

    initial begin
        int p0;
        int i;
        rst_n        = 1'b0;
        block_valid  = 1'b0;
        block        = '0;
        block_last   = 1'b0;
        block_nbytes = '0;
        word_ready   = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_word_valid", {31'd0, word_valid}, 32'd0);
        chk("rst_block_ready", {31'd0, block_ready}, 32'd1);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_word_last", {31'd0, word_last}, 32'd0);
        chk("rst_word_keep", {28'd0, word_keep}, 32'hF);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single full block: known words, first word right after the write.
        ready_mode = 1;
        pop_cyc.delete();
        @(posedge clk);
        send_block(128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b0, 5'd0);
        #1 block_valid = 1'b0;
        wait_drain("single");
        chk("single_words", pop_cyc.size(), 32'd4);
        if (pop_cyc.size() == 4) begin
            chk("single_latency", pop_cyc[0], last_acc_cyc + 1);
            chk("single_no_bubble", pop_cyc[3] - pop_cyc[0], 32'd3);
        end

        // Short last blocks: 6 bytes and the 0-means-16 case.
        @(posedge clk);
        send_block(128'h0102030405060708090A0B0C0D0E0F10, 1'b1, 5'd6);
        #1 block_valid = 1'b0;
        wait_drain("nb6");
        @(posedge clk);
        send_block(128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF, 1'b1, 5'd0);
        #1 block_valid = 1'b0;
        wait_drain("nb0");

        // Three back-to-back blocks: 12 words in 12 consecutive cycles.
        pop_cyc.delete();
        @(posedge clk);
        for (i = 0; i < 3; i++) begin
            send_block({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, 5'd0);
        end
        #1 block_valid = 1'b0;
        wait_drain("b2b");
        chk("b2b_words", pop_cyc.size(), 32'd12);
        if (pop_cyc.size() == 12) begin
            chk("b2b_no_bubble", pop_cyc[11] - pop_cyc[0], 32'd11);
        end

        // Stall with two blocks buffered, then release.
        ready_mode = 0;
        @(posedge clk);
        send_block({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, 5'd0);
        send_block({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1, 5'd11);
        #1 block_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("stall_block_ready", {31'd0, block_ready}, 32'd0);
        repeat (4) @(negedge clk);
        ready_mode = 1;
        wait_drain("stall");

        // Randomized traffic with random backpressure and upstream gaps.
        ready_mode = 2;
        @(posedge clk);
        for (i = 0; i < 150; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            if (gap != 0) begin
                #1 block_valid = 1'b0;
                repeat (gap) @(posedge clk);
            end
            send_block({$urandom(), $urandom(), $urandom(), $urandom()},
                       ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 16)));
        end
        #1 block_valid = 1'b0;
        ready_mode = 1;
        wait_drain("random");

        // Reset after word 1 of a block, then a fresh block from word 0.
        ready_mode = 1;
        p0 = pops;
        @(posedge clk);
        send_block({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, 5'd0);
        #1 block_valid = 1'b0;
        for (i = 0; i < 100 && pops < p0 + 2; i++) @(negedge clk);
        chk("midrst_progress", {31'd0, pops >= p0 + 2}, 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        sb.delete();
        accepted = 0;
        retired  = 0;
        @(negedge clk);
        chk("midrst_word_valid", {31'd0, word_valid}, 32'd0);
        chk("midrst_empty", {31'd0, empty}, 32'd1);
        chk("midrst_block_ready", {31'd0, block_ready}, 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        send_block(128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 1'b1, 5'd16);
        #1 block_valid = 1'b0;
        wait_drain("postrst");

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, errors + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/be_block_streamer.md
BE_BLOCK_STREAMER -- requirements
Module: be_block_streamer

Interface
REQ-001 The block SHALL have a single clock; reset is asynchronous and active-low.
REQ-002 Port clk  input  1  rising-edge clock for all state.
REQ-003 Port rst_n  input  1  asynchronous active-low reset.
REQ-004 Port block_valid  input  1  upstream block present.
REQ-005 Port block_ready  output  1  streamer can accept a block this cycle.
REQ-006 Port block  input  128  BE data block; stream byte 0 = block[127:120].
REQ-007 Port block_last  input  1  block is final block of a message.
REQ-008 Port block_nbytes  input  5  valid bytes in a last block, 1..16; 0 treated as 16; ignored when block_last=0.
REQ-009 Port word_valid  output  1  output word present.
REQ-010 Port word_ready  input  1  downstream accepts word.
REQ-011 Port word  output  32  LE word; word[7:0] is the earliest stream byte.
REQ-012 Port word_keep  output  4  byte enables; bit i qualifies word[8i+7:8i].
REQ-013 Port word_last  output  1  final word of message.
REQ-014 Port empty  output  1  no buffered block and no pending word.

Function
REQ-015 The block SHALL contain a 2-entry block buffer (data, last, nbytes per entry) with write pointer, read pointer and count 0..2.
REQ-016 block_ready SHALL be (count != 2), combinational from registered state only.
REQ-017 A block SHALL be written on a clock edge where block_valid & block_ready; count increments unless a block retires on the same edge.
REQ-018 word_valid SHALL equal (count != 0); a word SHALL transfer on word_valid & word_ready.
REQ-019 A word index idx (0..3) SHALL select the output: word = byteswap(entry[127-32*idx : 96-32*idx]), i.e. idx 0 emits block[127:96] byte-swapped, idx 3 emits block[31:0] byte-swapped.
REQ-020 Words per entry SHALL be 4 for non-last entries, ceil(nbytes/4) for last entries (nbytes 0 = 16).
REQ-021 word_keep SHALL be 4'b1111 except on the final word of a last entry, where it is 4'b0001/0011/0111/1111 for nbytes mod 4 = 1/2/3/0.
REQ-022 word_last SHALL be 1 only on the final word of an entry with last=1.
REQ-023 On transfer of an entry's final word, the entry SHALL retire: read pointer advances (wraps 1->0), idx returns to 0, count decrements unless a block is written on the same edge.
REQ-024 On non-final word transfer, idx SHALL increment by 1.
REQ-025 Simultaneous write and retire SHALL leave count unchanged; with count=1 the new block's word 0 SHALL be presented the next cycle (no bubble).
REQ-026 Latency: a block written at edge t into an empty buffer SHALL present word 0 with word_valid=1 after edge t.
REQ-027 Sustained throughput SHALL be 1 word per cycle across block boundaries when word_ready=1 and upstream is never starved.
REQ-028 word, word_keep, word_last SHALL remain stable while word_valid=1 and word_ready=0.
REQ-029 empty SHALL equal (count == 0).
REQ-030 Bytes beyond nbytes in a last word SHALL be output as the stored data (not masked); only word_keep qualifies them.

Reset
REQ-031 While rst_n=0: count=0, idx=0, both pointers=0, so word_valid=0, block_ready=1, empty=1, word_last=0, word_keep=4'b1111.
REQ-032 Reset asserted mid-message SHALL discard all buffered entries and partial progress; buffer data registers need no reset.

Verification
REQ-033 One block 0x00112233_44556677_8899AABB_CCDDEEFF, last=0, word_ready=1 -> words 0x33221100, 0x77665544, 0xBBAA9988, 0xFFEEDDCC on consecutive cycles, keep=F, last=0.
REQ-034 Last block nbytes=6 -> exactly 2 words; second word keep=4'b0011, word_last=1; then empty=1.
REQ-035 Three blocks back-to-back with word_ready=1 -> 12 words in 12 consecutive cycles, no bubbles; block_ready falls only while count=2.
REQ-036 word_ready=0 with 2 blocks loaded -> block_ready=0, word held stable; release -> draining resumes in order, no loss/duplication.
REQ-037 Last block nbytes=0 -> 4 words, last word keep=F, word_last=1.
REQ-038 Assert rst_n=0 after word 1 of a block -> next cycle word_valid=0, empty=1, block_ready=1; after release a new block starts at idx 0.
